gemm_host_ctrl: RTL
===================

// Module: gemm_host_ctrl
// PURPOSE
//  Host-side initiator for the GEMM engine. Loads A, B and C matrices element-by-element from a
//  valid/ready input stream. Pulses the engine start and waits for engine done. Captures the result
//  matrix and streams it out row-major. Sits between the system fabric and the GEMM engine.
// PARAMETERS
//  DATA_WIDTH      64    element width, bits (signed two's complement)
//  MATRIX_WIDTH    4     columns per matrix
//  MATRIX_HEIGHT   4     rows per matrix
//  TIMEOUT_CYCLES  1024  max WAIT cycles before the engine is declared hung
// PORTS
//  iclk           in   1             clock
//  irst           in   1             synchronous, active-high reset
//  ialpha,ibeta   in   DATA_WIDTH    scalars, sampled on entry to START
//  iin_valid      in   1             input element valid
//  iin_data       in   DATA_WIDTH    input element
//  oin_ready      out  1             input element accepted when valid&&ready
//  oa_matrix      out  DW[H][W]      A bank to engine
//  ob_matrix      out  DW[H][W]      B bank to engine
//  oc_matrix      out  DW[H][W]      C bank to engine
//  oalpha,obeta   out  DATA_WIDTH    scalars to engine
//  ostart         out  1             one-cycle start pulse to engine
//  iengine_done   in   1             engine completion
//  iresult_matrix in   DW[H][W]      engine result, valid while iengine_done=1
//  oout_valid     out  1             result element valid
//  oout_data      out  DATA_WIDTH    result element
//  oout_last      out  1             final element of the matrix
//  iout_ready     in   1             downstream accept
//  obusy          out  1             high in any state except LOAD_A with idx==0
//  oerror         out  1             sticky timeout flag; cleared by irst or by the next accepted input element
// BEHAVIOUR
//  States: LOAD_A -> LOAD_B -> LOAD_C -> START -> WAIT -> DRAIN -> LOAD_A.
//  - Reset: state=LOAD_A, idx=0, all banks 0, alpha/beta regs 0.
//    ostart=0, oout_valid=0, oout_last=0, oerror=0, oin_ready=0 in the reset cycle.
//  - idx counts 0..H*W-1 in row-major order: row=idx/W, col=idx%W.
//  - LOAD_x:
//    - oin_ready=1.
//    - On valid&&ready, write bank_x[row][col] and increment idx.
//    - At idx==H*W-1 with a handshake, idx wraps to 0 and the state advances.
//  - START (1 cycle): latch ialpha/ibeta into oalpha/obeta, ostart=1, timer=0, go to WAIT. oin_ready=0.
//  - WAIT:
//    - On iengine_done=1, copy iresult_matrix into the result register the same edge, then go to DRAIN.
//    - Else timer++. At timer==TIMEOUT_CYCLES-1 set oerror=1, go to LOAD_A; the result register is unchanged.
//  - DRAIN:
//    - oout_valid=1, oout_data=result[row][col], oout_last=(idx==H*W-1).
//    - Data is held stable while iout_ready=0. Advance idx on a handshake.
//    - After the last handshake, go to LOAD_A with idx=0.
//  - Banks A/B/C hold their values after START; the engine may read them at any time until the next LOAD overwrites them.
//  - Input elements offered outside LOAD_x are not accepted (ready=0); there is no drop or overflow.
//  - iengine_done outside WAIT is ignored.
//  - irst mid-operation (any state) aborts the job: full reset values, no start pulse, no partial output.
//  - Arithmetic: only index/timer counters. The counter width is $clog2(H*W) and the timer width is $clog2(TIMEOUT_CYCLES)+1.
// STRUCTURE
//  - Shared package gemm_pkg:
//    - typedef enum state_t {LOAD_A, LOAD_B, LOAD_C, START, WAIT, DRAIN}.
//    - localparam NUM_ELEMS = MATRIX_HEIGHT*MATRIX_WIDTH.
//    - Matrix typedef shared with the engine.
//  - Sub-module gemm_elem_counter:
//    - idx counter with inc/clear, row/col decode and last flag.
//    - Reused for the load and drain phases.
// TESTING
//  1. Reset mid-LOAD_B (5 elems in) -> all outputs at reset values, next 16 elems refill A.
//  2. Load A=identity, B=2..17, C=0, alpha=1, beta=0. Engine model returns A*B
//     -> ostart exactly 1 cycle after the 48th handshake; out stream is 2..17, oout_last on the 16th.
//  3. Drain with iout_ready toggling 1,0,0,1... -> no duplicated or skipped element, data stable while stalled.
//  4. Engine never asserts done -> oerror=1 after TIMEOUT_CYCLES in WAIT, state LOAD_A, no oout_valid.
//  5. iin_valid held high during WAIT/DRAIN -> oin_ready=0 throughout, bank contents unchanged.
//  6. Spurious iengine_done in LOAD_C -> ignored; correct single start pulse follows load completion.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared types and sizing for the GEMM host controller and engine.
// Matrix geometry and the element type are fixed here so both sides agree on the bank layout.
package gemm_pkg;

  localparam int unsigned DATA_WIDTH    = 64;
  localparam int unsigned MATRIX_WIDTH  = 4;
  localparam int unsigned MATRIX_HEIGHT = 4;
  localparam int unsigned NUM_ELEMS     = MATRIX_HEIGHT * MATRIX_WIDTH;

  localparam int unsigned IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int unsigned ROW_W = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int unsigned COL_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

  typedef logic signed [DATA_WIDTH-1:0] elem_t;
  typedef elem_t [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0] matrix_t;

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_C,
    START,
    WAIT,
    DRAIN
  } state_t;

endpackage

// File: rtl/gemm_elem_counter.sv
// Row-major element index shared by the load and drain phases.
// Wraps to zero after the last element; row/col are decoded from the index.
module gemm_elem_counter
  import gemm_pkg::*;
(
  input  logic             iclk,
  input  logic             irst,
  input  logic             iinc,
  input  logic             iclr,
  output logic [IDX_W-1:0] oidx,
  output logic [ROW_W-1:0] orow,
  output logic [COL_W-1:0] ocol,
  output logic             olast
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge iclk) begin
    if (irst || iclr) begin
      idx_q <= '0;
    end else if (iinc) begin
      idx_q <= olast ? '0 : idx_q + IDX_W'(1);
    end
  end

  assign oidx  = idx_q;
  assign orow  = ROW_W'(idx_q / IDX_W'(MATRIX_WIDTH));
  assign ocol  = COL_W'(idx_q % IDX_W'(MATRIX_WIDTH));
  assign olast = (idx_q == IDX_W'(NUM_ELEMS - 1));

endmodule

// File: rtl/gemm_host_ctrl.sv
// Host-side initiator for the GEMM engine: streams in A/B/C, kicks the engine, waits for done
// (with a hang timeout) and streams the captured result out row-major.
module gemm_host_ctrl
  import gemm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic [DATA_WIDTH-1:0] ialpha,
  input  logic [DATA_WIDTH-1:0] ibeta,
  input  logic                  iin_valid,
  input  logic [DATA_WIDTH-1:0] iin_data,
  output logic                  oin_ready,
  output matrix_t               oa_matrix,
  output matrix_t               ob_matrix,
  output matrix_t               oc_matrix,
  output logic [DATA_WIDTH-1:0] oalpha,
  output logic [DATA_WIDTH-1:0] obeta,
  output logic                  ostart,
  input  logic                  iengine_done,
  input  matrix_t               iresult_matrix,
  output logic                  oout_valid,
  output logic [DATA_WIDTH-1:0] oout_data,
  output logic                  oout_last,
  input  logic                  iout_ready,
  output logic                  obusy,
  output logic                  oerror
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t                  state_q;
  matrix_t                 a_q, b_q, c_q, res_q;
  logic [DATA_WIDTH-1:0]   alpha_q, beta_q;
  logic [TIMER_W-1:0]      timer_q;
  logic                    start_q, in_ready_q, out_valid_q, error_q;

  logic [IDX_W-1:0]        idx;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic                    last;
  logic                    in_hs, out_hs;

  assign in_hs  = iin_valid && in_ready_q;
  assign out_hs = out_valid_q && iout_ready;

  gemm_elem_counter u_counter (
    .iclk  (iclk),
    .irst  (irst),
    .iinc  (in_hs || out_hs),
    .iclr  (state_q == WAIT),
    .oidx  (idx),
    .orow  (row),
    .ocol  (col),
    .olast (last)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_q       <= '0;
      alpha_q     <= '0;
      beta_q      <= '0;
      timer_q     <= '0;
      start_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        LOAD_A, LOAD_B, LOAD_C: begin
          in_ready_q <= 1'b1;
          if (in_hs) begin
            error_q <= 1'b0;
            unique case (state_q)
              LOAD_A:  a_q[row][col] <= iin_data;
              LOAD_B:  b_q[row][col] <= iin_data;
              default: c_q[row][col] <= iin_data;
            endcase
            if (last) begin
              unique case (state_q)
                LOAD_A: state_q <= LOAD_B;
                LOAD_B: state_q <= LOAD_C;
                default: begin
                  // Scalars are captured here so they are valid alongside the start pulse.
                  state_q    <= START;
                  in_ready_q <= 1'b0;
                  start_q    <= 1'b1;
                  alpha_q    <= ialpha;
                  beta_q     <= ibeta;
                end
              endcase
            end
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (iengine_done) begin
            res_q       <= iresult_matrix;
            out_valid_q <= 1'b1;
            state_q     <= DRAIN;
          end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            error_q    <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= LOAD_A;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        DRAIN: begin
          if (out_hs && last) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= LOAD_A;
          end
        end
        default: state_q <= LOAD_A;
      endcase
    end
  end

  assign oin_ready  = in_ready_q;
  assign oa_matrix  = a_q;
  assign ob_matrix  = b_q;
  assign oc_matrix  = c_q;
  assign oalpha     = alpha_q;
  assign obeta      = beta_q;
  assign ostart     = start_q;
  assign oout_valid = out_valid_q;
  assign oout_data  = res_q[row][col];
  assign oout_last  = out_valid_q && last;
  assign obusy      = !((state_q == LOAD_A) && (idx == '0));
  assign oerror     = error_q;

endmodule
